// File: rtl/mult_post.sv
// Purpose: converts sign/magnitude products from the multiplier pipeline into two's complement and buffers them in a small FIFO.
// Latency: one cycle from an in_rdy strobe into an empty buffer to res_valid with the converted value on res (show-ahead head).
// Backpressure: none toward the pipeline; res_ready pops the head, and an input arriving while full (with no pop) is dropped and sets sticky ovf.
module mult_post #(
  parameter int N     = 4,
  parameter int M     = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_rdy,
  input  logic [M+N-1:0]           in_acc,
  input  logic                     in_flag,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [M+N:0]             res,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     ovf,
  input  logic                     clr_ovf
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int RW = M + N + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [RW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [RW-1:0] ext_acc;
  logic [RW-1:0] conv;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  // Sign conversion and push/pop/drop decisions for this cycle.
  always_comb begin
    ext_acc   = {1'b0, in_acc};
    // Negating zero wraps back to zero, so there is no negative zero.
    conv      = in_flag ? (~ext_acc + RW'(1)) : ext_acc;
    full      = (fill == FULL_CNT);
    res_valid = (fill != '0);
    pop       = res_valid & res_ready;
    push      = in_rdy & (~full | pop);
    drop      = in_rdy & full & ~pop;
    res       = res_valid ? mem[rd_ptr] : '0;
  end

  // Storage array; contents are only visible through res while res_valid is high, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= conv;
    end
  end

  // Pointers and occupancy count; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fill <= fill + CW'(1);
        2'b01:   fill <= fill - CW'(1);
        default: fill <= fill;
      endcase
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_post.sv
// Self-checking bench for mult_post (N=M=4, DEPTH=4).
// Expected results are queued when stimulus is driven and compared when popped.
// Each scenario task does its own comparisons.
module tb_mult_post;

  logic       clk;
  logic       rstn;
  logic       in_rdy;
  logic [7:0] in_acc;
  logic       in_flag;
  logic       res_valid;
  logic       res_ready;
  logic [8:0] res;
  logic [2:0] fill;
  logic       ovf;
  logic       clr_ovf;

  int checks = 0;
  int errors = 0;

  logic [8:0] sb[$];
  logic       m_ovf = 1'b0;

  logic       popped;
  logic [8:0] obs;
  logic [8:0] expv;

  mult_post #(.N(4), .M(4), .DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .in_rdy(in_rdy), .in_acc(in_acc), .in_flag(in_flag),
    .res_valid(res_valid), .res_ready(res_ready), .res(res), .fill(fill),
    .ovf(ovf), .clr_ovf(clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] conv(input logic [7:0] a, input logic f);
    logic [8:0] e;
    e = {1'b0, a};
    return f ? (9'd0 - e) : e;
  endfunction

  // Drive one cycle of stimulus, update the scoreboard model, and report any pop.
  task automatic drive(input logic r, input logic [7:0] a, input logic f,
                       input logic rr, input logic c,
                       output logic pp, output logic [8:0] ob, output logic [8:0] ex);
    logic was_full;
    in_rdy = r; in_acc = a; in_flag = f; res_ready = rr; clr_ovf = c;
    #1;
    was_full = (sb.size() == 4);
    pp = rr && (sb.size() != 0);
    ob = res;
    ex = pp ? sb.pop_front() : 9'd0;
    if (r && (!was_full || pp)) sb.push_back(conv(a, f));
    if (r && was_full && !pp) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    @(posedge clk); #1;
    in_rdy = 1'b0; in_acc = 8'd0; in_flag = 1'b0; res_ready = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", res_valid); end
    checks++; if (res !== 9'd0) begin errors++; $display("FAIL rst_res got %h exp 000", res); end
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL rst_fill got %0d exp 0", fill); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b exp 0", ovf); end
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic test_single_pos;
    drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, popped, obs, expv);
    checks++; if (fill !== 3'd0 || res_valid !== 1'b0) begin errors++; $display("FAIL empty_pop fill %0d valid %b exp 0 0", fill, res_valid); end
    drive(1'b1, 8'd35, 1'b0, 1'b0, 1'b0, popped, obs, expv);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL sp_valid got %b exp 1", res_valid); end
    checks++; if (res !== 9'h023) begin errors++; $display("FAIL sp_res got %h exp 023", res); end
    checks++; if (fill !== 3'd1) begin errors++; $display("FAIL sp_fill got %0d exp 1", fill); end
    drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, popped, obs, expv);
    checks++; if (!popped || obs !== expv) begin errors++; $display("FAIL sp_pop got %h exp %h", obs, expv); end
    checks++; if (fill !== 3'd0 || res_valid !== 1'b0 || res !== 9'd0) begin errors++; $display("FAIL sp_after fill %0d valid %b res %h exp 0 0 000", fill, res_valid, res); end
  endtask

  task automatic test_neg_zero;
    drive(1'b1, 8'd35, 1'b1, 1'b0, 1'b0, popped, obs, expv);
    checks++; if (res !== 9'h1DD) begin errors++; $display("FAIL neg_res got %h exp 1DD", res); end
    drive(1'b1, 8'd0, 1'b1, 1'b1, 1'b0, popped, obs, expv);
    checks++; if (!popped || obs !== expv) begin errors++; $display("FAIL neg_pop got %h exp %h", obs, expv); end
    checks++; if (res !== 9'h000 || res_valid !== 1'b1) begin errors++; $display("FAIL negzero_res got %h valid %b exp 000 1", res, res_valid); end
    drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, popped, obs, expv);
    checks++; if (!popped || obs !== expv) begin errors++; $display("FAIL negzero_pop got %h exp %h", obs, expv); end
  endtask

  task automatic test_overflow;
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, popped, obs, expv);
      checks++; if (fill !== 3'(sb.size())) begin errors++; $display("FAIL ovf_fill%0d got %0d exp %0d", i, fill, sb.size()); end
      checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL ovf_flag%0d got %b exp %b", i, ovf, m_ovf); end
      checks++; if (res !== 9'd1) begin errors++; $display("FAIL ovf_hold%0d got %h exp 001", i, res); end
    end
    checks++; if (fill !== 3'd4 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_final fill %0d ovf %b exp 4 1", fill, ovf); end
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, popped, obs, expv);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", ovf); end
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, popped, obs, expv);
      checks++; if (!popped || obs !== expv || obs !== 9'(i)) begin errors++; $display("FAIL ovf_drain%0d got %h exp %h", i, obs, 9'(i)); end
    end
    checks++; if (fill !== 3'd0 || res_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty fill %0d valid %b exp 0 0", fill, res_valid); end
  endtask

  task automatic test_full_push_pop;
    logic [8:0] order [4];
    for (int i = 1; i <= 4; i++) drive(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, popped, obs, expv);
    drive(1'b1, 8'd9, 1'b0, 1'b1, 1'b0, popped, obs, expv);
    checks++; if (!popped || obs !== 9'd1 || obs !== expv) begin errors++; $display("FAIL fpp_pop got %h exp 001", obs); end
    checks++; if (fill !== 3'd4 || ovf !== 1'b0) begin errors++; $display("FAIL fpp_state fill %0d ovf %b exp 4 0", fill, ovf); end
    order[0] = 9'd2; order[1] = 9'd3; order[2] = 9'd4; order[3] = 9'd9;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, popped, obs, expv);
      checks++; if (!popped || obs !== expv || obs !== order[i]) begin errors++; $display("FAIL fpp_drain%0d got %h exp %h", i, obs, order[i]); end
    end
  endtask

  task automatic test_wrap;
    logic [7:0] v;
    drive(1'b1, 8'd101, 1'b0, 1'b0, 1'b0, popped, obs, expv);
    drive(1'b1, 8'd102, 1'b1, 1'b0, 1'b0, popped, obs, expv);
    for (int i = 0; i < 8; i++) begin
      v = 8'($urandom_range(0, 255));
      drive(1'b1, v, 1'($urandom_range(0, 1)), 1'b1, 1'b0, popped, obs, expv);
      checks++; if (!popped || obs !== expv) begin errors++; $display("FAIL wrap_pop%0d got %h exp %h", i, obs, expv); end
      checks++; if (fill !== 3'(sb.size())) begin errors++; $display("FAIL wrap_fill%0d got %0d exp %0d", i, fill, sb.size()); end
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, popped, obs, expv);
      checks++; if (!popped || obs !== expv) begin errors++; $display("FAIL wrap_drain%0d got %h exp %h", i, obs, expv); end
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(200 + i), 1'b0, 1'b0, 1'b0, popped, obs, expv);
    drive(1'b1, 8'd250, 1'b0, 1'b0, 1'b1, popped, obs, expv);
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL wrap_setwins got %b exp 1", ovf); end
    drive(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, popped, obs, expv);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL wrap_clr got %b exp 0", ovf); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, popped, obs, expv);
      checks++; if (!popped || obs !== expv || obs !== 9'(200 + i)) begin errors++; $display("FAIL wrap_full_drain%0d got %h exp %h", i, obs, 9'(200 + i)); end
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) drive(1'b1, 8'(10 + i), 1'b0, 1'b0, 1'b0, popped, obs, expv);
    checks++; if (fill !== 3'd3) begin errors++; $display("FAIL rm_fill_before got %0d exp 3", fill); end
    #2 rstn = 1'b0;
    #1;
    sb.delete();
    m_ovf = 1'b0;
    checks++; if (res_valid !== 1'b0 || fill !== 3'd0 || res !== 9'd0) begin errors++; $display("FAIL rm_async valid %b fill %0d res %h exp 0 0 000", res_valid, fill, res); end
    @(negedge clk);
    rstn = 1'b1;
    drive(1'b1, 8'd77, 1'b1, 1'b0, 1'b0, popped, obs, expv);
    checks++; if (res_valid !== 1'b1 || fill !== 3'd1 || res !== 9'h1B3) begin errors++; $display("FAIL rm_head valid %b fill %0d res %h exp 1 1 1B3", res_valid, fill, res); end
    drive(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, popped, obs, expv);
    checks++; if (!popped || obs !== expv) begin errors++; $display("FAIL rm_pop got %h exp %h", obs, expv); end
  endtask

  initial begin
    rstn = 1'b0; in_rdy = 1'b0; in_acc = 8'd0; in_flag = 1'b0;
    res_ready = 1'b0; clr_ovf = 1'b0;
    test_reset;
    test_single_pos;
    test_neg_zero;
    test_overflow;
    test_full_push_pop;
    test_wrap;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_post.md
MULT_POST -- requirements
Module: mult_post

Interface
REQ-001 Parameter N, default 4: multiplicand width, matching the multiplier pipeline cells.
REQ-002 Parameter M, default 4: multiplier width, matching the multiplier pipeline cells.
REQ-003 Parameter DEPTH, default 4: result buffer entries; power of two, at least 2.
REQ-004 Derived widths: CW = log2(DEPTH)+1; RW = M+N+1.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rstn  input  1  asynchronous, active-low reset.
REQ-007 in_rdy  input  1  result-valid strobe from the last multiplier cell.
REQ-008 in_acc  input  M+N  unsigned product magnitude from the last cell.
REQ-009 in_flag  input  1  sign of the product (1 = negative) from the last cell.
REQ-010 res_valid  output  1  buffer head holds a result.
REQ-011 res_ready  input  1  consumer accepts the head this cycle.
REQ-012 res  output  RW  signed two's-complement product at the buffer head.
REQ-013 fill  output  CW  number of occupied entries, 0..DEPTH.
REQ-014 ovf  output  1  sticky flag: a result was dropped because the buffer was full.
REQ-015 clr_ovf  input  1  synchronous clear of ovf.

Function
REQ-016 The block SHALL convert each accepted input to a signed value:
- in_flag=0: res = zero-extended in_acc.
- in_flag=1: res = two's complement negation of zero-extended in_acc, computed at RW bits.
REQ-017 in_flag=1 with in_acc=0 SHALL produce res=0; there is no negative zero.
REQ-018 The upstream pipeline cannot stall, so there is no backpressure toward it.
- A write is attempted on every cycle with in_rdy=1.
- in_acc and in_flag are ignored while in_rdy=0.
REQ-019 push = in_rdy and (fill<DEPTH or pop).
- pop = res_valid and res_ready.
- A push while full SHALL succeed when a pop occurs in the same cycle.
REQ-020 drop = in_rdy and fill=DEPTH and not pop.
- On drop, the input SHALL be discarded, buffer contents and fill SHALL be unchanged, and ovf SHALL be set on the next edge.
REQ-021 The buffer SHALL be circular with write and read pointers that wrap modulo DEPTH.
REQ-022 fill update rules:
- fill increments on push without pop.
- fill decrements on pop without push.
- fill is unchanged on simultaneous push and pop, or on neither.
REQ-023 res_valid SHALL equal (fill != 0).
- res SHALL present the oldest entry (show-ahead).
- res SHALL be held stable while res_valid=1 and res_ready=0.
REQ-024 Latency: with the buffer empty, in_rdy sampled high at edge k SHALL give res_valid=1 and the converted value on res after edge k (one cycle).
REQ-025 Push and pop on an empty buffer in the same cycle is impossible, since res_valid=0; the push alone SHALL occur.
REQ-026 Order SHALL be preserved: results leave in exactly the order accepted.
REQ-027 ovf is sticky until cleared:
- clr_ovf=1 clears ovf on the next edge.
- If drop and clr_ovf occur in the same cycle, ovf SHALL be 1 (set wins).
REQ-028 res_ready with res_valid=0 SHALL have no effect.
REQ-029 res SHALL read as 0 whenever res_valid=0.

Reset
REQ-030 While rstn=0, asynchronously:
- res_valid=0, res=0, fill=0, ovf=0.
- Both pointers are 0.
REQ-031 Assertion of rstn mid-stream SHALL discard all buffered results; entries in flight upstream are not recovered.
REQ-032 The first edge after rstn deasserts SHALL accept in_rdy normally.

Verification (N=M=4, DEPTH=4)
REQ-033 Single positive value.
- Stimulus: reset, then in_rdy pulse with in_acc=35, in_flag=0.
- Response: next cycle res_valid=1, res=9'h023, fill=1; after one res_ready cycle, fill=0 and res_valid=0.
REQ-034 Negative and zero values.
- Stimulus: in_acc=35 with in_flag=1, then in_acc=0 with in_flag=1.
- Response: res=9'h1DD, then res=9'h000.
REQ-035 Full buffer and overflow.
- Stimulus: res_ready=0; six consecutive in_rdy pushes, values 1..6.
- Response: fill reaches 4; ovf=1 from the cycle after the 5th push.
- Response: draining yields 1,2,3,4; values 5 and 6 are lost.
REQ-036 Full with simultaneous push and pop.
- Stimulus: buffer full with 1..4; in_rdy with value 9 and res_ready=1 in the same cycle.
- Response: fill stays 4, ovf stays 0; drain order is 2,3,4,9.
REQ-037 Pointer wrap under continuous traffic.
- Stimulus: 10 pushes interleaved with pops, keeping fill in 1..3.
- Response: output order is intact across pointer wrap; clr_ovf coincident with a drop leaves ovf=1.
REQ-038 Reset mid-operation.
- Stimulus: rstn asserted with fill=3.
- Response: immediately res_valid=0, fill=0, res=0; the next push after release appears as the head.
